// File: rtl/elevator_call_panel.sv
// Hall-call front end: 2-flop button sync, per-floor debounce, per-floor call FSM.
// Optional CALL_STATS_EN adds the saturating served_cnt output.
module elevator_call_panel #(
  parameter int NUM_FLOORS      = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS:1]   btn_n,
  input  logic [NUM_FLOORS:1]   floor_at,
  input  logic [NUM_FLOORS:1]   clr,
  output logic [NUM_FLOORS:1]   call,
  output logic [NUM_FLOORS:1]   btn_db,
  output logic                  any_call,
  output logic                  clr_err
`ifdef CALL_STATS_EN
  ,
  output logic [7:0]            served_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALLED   = 2'd1,
    CLR_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_FLOORS:1] sync1;
  logic [NUM_FLOORS:1] sync_n;
  logic [NUM_FLOORS:1] btn_db_d;
  logic [NUM_FLOORS:1] db_rise;
  logic [NUM_FLOORS:1] db_fall;
  logic [NUM_FLOORS:1] clr_ok;
  logic [NUM_FLOORS:1] call_d;
  logic [NUM_FLOORS:1] retire;
  logic                clr_err_d;
  logic [CNT_W-1:0]    cnt_q [NUM_FLOORS:1];
  logic [CNT_W-1:0]    cnt_d [NUM_FLOORS:1];
  state_t              state_q [NUM_FLOORS:1];
  state_t              state_d [NUM_FLOORS:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync_n <= '1;
    end else begin
      sync1  <= btn_n;
      sync_n <= sync1;
    end
  end

  // A sample counts toward a change when its active-high level (~sync_n) differs from btn_db
  always_comb begin
    btn_db_d = btn_db;
    db_rise  = '0;
    db_fall  = '0;
    for (int unsigned i = 1; i <= NUM_FLOORS; i++) begin
      cnt_d[i] = '0;
      if (sync_n[i] == btn_db[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          btn_db_d[i] = ~btn_db[i];
          db_rise[i]  = ~btn_db[i];
          db_fall[i]  = btn_db[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign clr_ok    = clr & floor_at;
  assign clr_err_d = |(clr & ~floor_at);

  always_comb begin
    call_d = '0;
    retire = '0;
    for (int unsigned i = 1; i <= NUM_FLOORS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          if (db_rise[i]) state_d[i] = CALLED;
        end
        CALLED: begin
          if (clr_ok[i]) state_d[i] = btn_db[i] ? CLR_WAIT : IDLE;
        end
        CLR_WAIT: begin
          if (db_fall[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
      call_d[i] = (state_d[i] != IDLE);
      retire[i] = (state_q[i] != IDLE) && (state_d[i] == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_db  <= '0;
      call    <= '0;
      clr_err <= 1'b0;
      for (int unsigned i = 1; i <= NUM_FLOORS; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      btn_db  <= btn_db_d;
      call    <= call_d;
      clr_err <= clr_err_d;
      for (int unsigned i = 1; i <= NUM_FLOORS; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign any_call = |call;

`ifdef CALL_STATS_EN
  logic [8:0] served_sum;

  always_comb begin
    served_sum = {1'b0, served_cnt};
    for (int unsigned i = 1; i <= NUM_FLOORS; i++) begin
      if (retire[i] && served_sum != 9'd255) served_sum = served_sum + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) served_cnt <= '0;
    else        served_cnt <= served_sum[7:0];
  end
`else
  logic unused_retire;
  assign unused_retire = |retire;
`endif

endmodule

// File: tb/tb_elevator_call_panel.sv
// Bench for elevator_call_panel: directed test-plan steps then random traffic,
// every cycle compared against a behavioural model of the hall-call rules.
module tb_elevator_call_panel;

  localparam int NF = 3;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF:1]   btn_n;
  logic [NF:1]   floor_at;
  logic [NF:1]   clr;
  logic [NF:1]   call;
  logic [NF:1]   btn_db;
  logic          any_call;
  logic          clr_err;
`ifdef CALL_STATS_EN
  logic [7:0]    served_cnt;
`endif

  int checks = 0;
  int errors = 0;

  elevator_call_panel #(.NUM_FLOORS(NF), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .floor_at(floor_at), .clr(clr),
    .call(call), .btn_db(btn_db), .any_call(any_call), .clr_err(clr_err)
`ifdef CALL_STATS_EN
    , .served_cnt(served_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: synchronizer as a 2-deep delay, debounce as a run length
  logic [NF:1] m_s1, m_s2, m_db, m_call, m_wait;
  int          m_run [1:NF];
  logic        m_err;
  int          m_served;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_db = '0; m_call = '0; m_wait = '0;
    m_err = 1'b0; m_served = 0;
    for (int i = 1; i <= NF; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NF:1] old_db;
    int retired;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_db = m_db;
    retired = 0;
    for (int i = 1; i <= NF; i++) begin
      logic rise, fall, ok;
      rise = 1'b0; fall = 1'b0;
      if ((~m_s2[i]) != old_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_db[i] = ~old_db[i];
          rise = ~old_db[i];
          fall = old_db[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      ok = clr[i] & floor_at[i];
      if (!m_call[i]) begin
        if (rise) m_call[i] = 1'b1;
      end else if (!m_wait[i]) begin
        if (ok) begin
          if (old_db[i]) m_wait[i] = 1'b1;
          else begin m_call[i] = 1'b0; retired++; end
        end
      end else if (fall) begin
        m_call[i] = 1'b0; m_wait[i] = 1'b0; retired++;
      end
    end
    m_err = |(clr & ~floor_at);
    m_served = m_served + retired;
    if (m_served > 255) m_served = 255;
    m_s2 = m_s1;
    m_s1 = btn_n;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".call"},     32'(call),     32'(m_call));
    check({tag, ".btn_db"},   32'(btn_db),   32'(m_db));
    check({tag, ".any_call"}, 32'(any_call), 32'(|m_call));
    check({tag, ".clr_err"},  32'(clr_err),  32'(m_err));
`ifdef CALL_STATS_EN
    check({tag, ".served"},   32'(served_cnt), 32'(m_served));
`endif
  endtask

  task automatic steps(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    rst_n = 1'b0; btn_n = '1; floor_at = 3'b001; clr = '0;
    model_reset();
    steps("reset", 2);
    check("reset.call0", 32'(call), 32'd0);
    check("reset.clr_err0", 32'(clr_err), 32'd0);
    rst_n = 1'b1;
    steps("idle", 3);

    // Floor 3 press: call rises on the 6th edge after the first low sample
    btn_n[3] = 1'b0;
    steps("press3", 5);
    check("press3.before", 32'(call[3]), 32'd0);
    step("press3");
    check("press3.call", 32'(call), 32'b100);
    check("press3.db", 32'(btn_db), 32'b100);
    check("press3.any", 32'(any_call), 32'd1);
    steps("hold3", 6);

    // 2-cycle glitch on floor 2 must be filtered
    btn_n[2] = 1'b0;
    steps("glitch2", 2);
    btn_n[2] = 1'b1;
    steps("glitch2", 8);
    check("glitch2.db", 32'(btn_db[2]), 32'd0);
    check("glitch2.call", 32'(call[2]), 32'd0);

    // Qualified clear while held -> clear-wait, retire on debounced release
    floor_at = 3'b100; clr = 3'b100;
    step("clrheld3");
    clr = '0;
    check("clrheld3.call", 32'(call[3]), 32'd1);
    btn_n[3] = 1'b1;
    steps("rel3", 5);
    check("rel3.before", 32'(call[3]), 32'd1);
    step("rel3");
    check("rel3.call", 32'(call[3]), 32'd0);

    // Unqualified clear flags clr_err and leaves the call pending
    btn_n[1] = 1'b0;
    steps("press1", 6);
    btn_n[1] = 1'b1;
    steps("rel1", 7);
    floor_at = 3'b100; clr = 3'b001;
    step("badclr1");
    check("badclr1.err", 32'(clr_err), 32'd1);
    check("badclr1.call", 32'(call[1]), 32'd1);
    clr = '0;
    step("badclr1.after");
    check("badclr1.pulse", 32'(clr_err), 32'd0);
    floor_at = 3'b001; clr = 3'b001;
    step("goodclr1");
    clr = '0;
    check("goodclr1.call", 32'(call[1]), 32'd0);

    // Press completing together with a qualified clear: press wins
    btn_n[2] = 1'b0;
    steps("press2", 5);
    floor_at = 3'b010; clr = 3'b010;
    step("presswins2");
    clr = '0;
    check("presswins2.call", 32'(call[2]), 32'd1);
    btn_n[2] = 1'b1;
    steps("rel2", 6);
    clr = 3'b010;
    step("clr2");
    clr = '0;
    check("clr2.call", 32'(call[2]), 32'd0);

    // Reset discards pending calls; then a two-floor simultaneous retirement
    btn_n = 3'b010;
    steps("press13", 6);
    btn_n = 3'b111;
    steps("rel13", 6);
    check("press13.call", 32'(call), 32'b101);
    rst_n = 1'b0;
    step("midreset");
    rst_n = 1'b1;
    check("midreset.call", 32'(call), 32'd0);
    check("midreset.any", 32'(any_call), 32'd0);
    btn_n = 3'b010;
    steps("repress13", 6);
    btn_n = 3'b111;
    steps("rerel13", 6);
    floor_at = 3'b101; clr = 3'b101;
    step("dualclr");
    clr = '0;
    check("dualclr.call", 32'(call), 32'd0);
`ifdef CALL_STATS_EN
    check("dualclr.served", 32'(served_cnt), 32'd2);
`endif

    // Random traffic: buttons toggle rarely (mix of glitches and holds)
    for (int n = 0; n < 3000; n++) begin
      for (int i = 1; i <= NF; i++)
        if ($urandom_range(0, 5) == 0) btn_n[i] = ~btn_n[i];
      if ($urandom_range(0, 3) == 0) floor_at = 3'(1 << $urandom_range(0, 2));
      else if ($urandom_range(0, 15) == 0) floor_at = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rst_n = ($urandom_range(0, 299) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
